// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//
// Control sequencer for the 24-bit-instruction CPU datapath. It walks each
// instruction through FETCH -> DECODE -> EXECUTE -> (WRITEBACK), drives the
// datapath strobes, and handshakes with a wait-stated instruction memory.
// Run/single-step/halt and a fetch-timeout fault are provided for bring-up.
//
// Parameters:
//   COUNT_WIDTH    width of the retired-instruction counter
//   FETCH_TIMEOUT  FETCH cycles without imem_ready before entering FAULT
//                  (1..255)
//
// Ports:
//   CLK          system clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   opcode       instr[23:20] from the instruction register
//   Zero         ALU zero flag (BEQ condition)
//   run          level, free-run while high
//   step         one-cycle pulse, run exactly one instruction from IDLE
//   imem_ready   instruction memory has a valid word this cycle
//   imem_req     fetch request, high throughout FETCH
//   IRWrite      instruction-register load strobe
//   PCWrite      PC update strobe
//   PCSrc        0 = PC+1, 1 = PC+immediate
//   RegWrite     register-file write strobe
//   ALUSrc       0 = RA2 operand, 1 = immediate
//   ALUControl   00 ADD, 01 SUB, 10 AND, 11 OR
//   state        current state code
//   halted       HALT instruction executed
//   fault        fetch timeout occurred
//   instr_count  retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
  parameter int COUNT_WIDTH   = 16,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [3:0]             opcode,
  input  logic                   Zero,
  input  logic                   run,
  input  logic                   step,
  input  logic                   imem_ready,
  output logic                   imem_req,
  output logic                   IRWrite,
  output logic                   PCWrite,
  output logic                   PCSrc,
  output logic                   RegWrite,
  output logic                   ALUSrc,
  output logic [1:0]             ALUControl,
  output logic [2:0]             state,
  output logic                   halted,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t                 r_state;
  logic [3:0]             r_op;
  logic                   r_step_mode;
  logic [7:0]             r_tmo;
  logic [COUNT_WIDTH-1:0] r_count;

  logic   w_is_alu;
  logic   w_is_beq;
  logic   w_is_halt;
  logic   w_is_nop;
  logic   w_retire;
  logic   w_tmo_hit;
  state_t w_after_retire;

  // Instruction class comes from the latched opcode, never the live input.
  assign w_is_alu  = (r_op <= 4'd5);
  assign w_is_beq  = (r_op == OP_BEQ);
  assign w_is_halt = (r_op == OP_HALT);
  assign w_is_nop  = !(w_is_alu || w_is_beq || w_is_halt);

  assign w_retire  = ((r_state == S_EXECUTE) && (w_is_beq || w_is_nop)) ||
                     (r_state == S_WRITEBACK);

  // This FETCH cycle is the last one allowed without ready.
  assign w_tmo_hit = (r_tmo == TMO_LAST);

  // Single-step always parks in IDLE; free-run continues only while run is
  // still high at the retire cycle, so dropping run finishes the instruction.
  assign w_after_retire = (run && !r_step_mode) ? S_FETCH : S_IDLE;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_op        <= 4'h0;
      r_step_mode <= 1'b0;
      r_tmo       <= 8'd0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run || step) begin
            r_state     <= S_FETCH;
            r_step_mode <= !run;  // run wins when both are high
          end
        end
        S_FETCH: begin
          if (imem_ready) begin
            r_state <= S_DECODE;
            r_tmo   <= 8'd0;
          end else if (w_tmo_hit) begin
            r_state <= S_FAULT;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        S_DECODE: begin
          r_op    <= opcode;
          r_state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (w_is_halt)     r_state <= S_HALTED;
          else if (w_is_alu) r_state <= S_WRITEBACK;
          else               r_state <= w_after_retire;
        end
        S_WRITEBACK: r_state <= w_after_retire;
        S_HALTED:    r_state <= S_HALTED;
        S_FAULT:     r_state <= S_FAULT;
        default:     r_state <= S_IDLE;
      endcase

      if (w_retire) r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  // Strobes are decoded from the state register; IRWrite and PCSrc also
  // follow imem_ready / Zero in the same cycle, as the datapath expects.
  always_comb begin
    state       = r_state;
    imem_req    = (r_state == S_FETCH);
    IRWrite     = (r_state == S_FETCH) && imem_ready;
    PCWrite     = w_retire;
    PCSrc       = (r_state == S_EXECUTE) && w_is_beq && Zero;
    RegWrite    = (r_state == S_WRITEBACK);
    halted      = (r_state == S_HALTED);
    fault       = (r_state == S_FAULT);
    instr_count = r_count;

    // ALU configuration from the op register only: stable through EXECUTE
    // and WRITEBACK regardless of what the IR input does.
    ALUSrc     = 1'b0;
    ALUControl = 2'b00;
    case (r_op)
      4'h0:    ALUControl = 2'b00;
      4'h1:    ALUControl = 2'b01;
      4'h2:    ALUControl = 2'b10;
      4'h3:    ALUControl = 2'b11;
      4'h4: begin ALUControl = 2'b00; ALUSrc = 1'b1; end
      4'h5: begin ALUControl = 2'b01; ALUSrc = 1'b1; end
      4'h8:    ALUControl = 2'b01;
      default: ALUControl = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Randomized bench. Each instruction is expanded by a transaction-level model
// into its expected per-cycle trace (state, strobes, ALU config, counter);
// non-relevant inputs are randomized on every cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

  localparam int CW  = 4;   // narrow counter so wrap-around is exercised
  localparam int TMO = 15;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    opcode = 4'h0;
  logic          Zero = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          imem_ready = 1'b0;
  logic          imem_req, IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc;
  logic [1:0]    ALUControl;
  logic [2:0]    state;
  logic          halted, fault;
  logic [CW-1:0] instr_count;

  always #5 CLK = ~CLK;

  multicycle_sequencer #(.COUNT_WIDTH(CW), .FETCH_TIMEOUT(TMO)) dut (
    .CLK(CLK), .reset(reset), .opcode(opcode), .Zero(Zero), .run(run),
    .step(step), .imem_ready(imem_ready), .imem_req(imem_req),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
    .state(state), .halted(halted), .fault(fault),
    .instr_count(instr_count)
  );

  typedef struct {
    logic          r, s, rdy, z;
    logic [3:0]    op;
    logic [12:0]   exp;
    logic [CW-1:0] cnt;
  } cyc_t;

  cyc_t          q[$];
  logic          m_src;
  logic [1:0]    m_ctl;
  logic [CW-1:0] m_count;
  int            checks = 0;
  int            failures = 0;
  logic [12:0]   obs;
  logic [CW-1:0] obs_cnt;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [12:0] snap();
    return {state, imem_req, IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc,
            ALUControl, halted, fault};
  endfunction

  function automatic void model_reset();
    m_count = '0;
    m_src   = 1'b0;
    m_ctl   = 2'b00;
  endfunction

  // Opcode map: ADD/ADDI -> 00, SUB/SUBI/BEQ -> 01, AND 10, OR 11.
  function automatic void decode_model(input logic [3:0] op);
    case (op)
      4'h0, 4'h4:       m_ctl = 2'b00;
      4'h1, 4'h5, 4'h8: m_ctl = 2'b01;
      4'h2:             m_ctl = 2'b10;
      4'h3:             m_ctl = 2'b11;
      default:          m_ctl = 2'b00;
    endcase
    m_src = (op == 4'h4) || (op == 4'h5);
  endfunction

  function automatic void push(input logic r, input logic s, input logic rdy,
                               input logic [3:0] o, input logic z,
                               input logic [2:0] st, input logic req,
                               input logic irw, input logic pcw,
                               input logic src, input logic rw,
                               input logic h, input logic f);
    cyc_t c;
    c.r = r; c.s = s; c.rdy = rdy; c.op = o; c.z = z;
    c.exp = {st, req, irw, pcw, src, rw, m_src, m_ctl, h, f};
    c.cnt = m_count;
    q.push_back(c);
  endfunction

  function automatic void gen_idle(input logic r, input logic s);
    push(r, s, rb(), rop(), rb(), 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic void gen_hold(input logic [2:0] st, input logic h,
                                   input logic f, input int n);
    for (int i = 0; i < n; i++)
      push(rb(), rb(), rb(), rop(), rb(), st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, h, f);
  endfunction

  // One instruction starting in FETCH. Returns 1 when the sequencer is
  // expected to go straight to FETCH afterwards, 0 for IDLE (or HALT).
  function automatic bit gen_instr(input logic [3:0] op, input int waits,
                                   input logic z, input bit run_mode,
                                   input logic rr);
    for (int i = 0; i < waits; i++)
      push(rb(), rb(), 1'b0, rop(), rb(), 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(rb(), rb(), 1'b1, rop(), rb(), 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(rb(), rb(), rb(), op, rb(), 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    decode_model(op);
    if (op == 4'hF) begin
      push(rb(), rb(), rb(), rop(), rb(), 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      return 1'b0;
    end
    if (op <= 4'd5) begin
      push(rb(), rb(), rb(), rop(), rb(), 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push(rr, rb(), rb(), rop(), rb(), 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end else if (op == 4'h8) begin
      push(rr, rb(), rb(), rop(), z, 3'd3, 1'b0, 1'b0, 1'b1, z, 1'b0, 1'b0, 1'b0);
    end else begin
      push(rr, rb(), rb(), rop(), rb(), 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    m_count = m_count + 1'b1;
    return run_mode && rr;
  endfunction

  task automatic drive(input cyc_t c);
    run = c.r; step = c.s; imem_ready = c.rdy; opcode = c.op; Zero = c.z;
    @(negedge CLK);
    obs = snap();
    obs_cnt = instr_count;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    cyc_t c;
    #3;
    reset = 1'b0;
    #2;
    checks++;
    if (snap() !== 13'd0 || instr_count !== '0) begin
      failures++;
      $display("FAIL reset_async outputs=%h count=%0d required 0/0", snap(), instr_count);
    end
    @(posedge CLK);
    #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) gen_idle(1'b0, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive(c);
      checks++;
      if (obs !== c.exp || obs_cnt !== c.cnt) begin
        failures++;
        $display("FAIL reset_idle outputs=%h count=%0d required %h/%0d", obs, obs_cnt, c.exp, c.cnt);
      end
    end
  endtask

  task automatic test_run_alu();
    cyc_t c;
    gen_idle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) void'(gen_instr(4'h0, 0, rb(), 1'b1, (i < 4)));
    gen_idle(1'b0, 1'b0);
    gen_idle(1'b0, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive(c);
      checks++;
      if (obs !== c.exp || obs_cnt !== c.cnt) begin
        failures++;
        $display("FAIL run_add outputs=%h count=%0d required %h/%0d", obs, obs_cnt, c.exp, c.cnt);
      end
    end
  endtask

  task automatic test_step_beq();
    cyc_t c;
    gen_idle(1'b0, 1'b0);
    gen_idle(1'b0, 1'b1);
    void'(gen_instr(4'h8, 0, 1'b1, 1'b0, rb()));
    gen_idle(1'b0, 1'b0);
    gen_idle(1'b0, 1'b1);
    void'(gen_instr(4'h8, 0, 1'b0, 1'b0, rb()));
    gen_idle(1'b0, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive(c);
      checks++;
      if (obs !== c.exp || obs_cnt !== c.cnt) begin
        failures++;
        $display("FAIL step_beq outputs=%h count=%0d required %h/%0d", obs, obs_cnt, c.exp, c.cnt);
      end
    end
  endtask

  task automatic test_wait_addi();
    cyc_t c;
    gen_idle(1'b1, 1'b0);
    void'(gen_instr(4'h4, 3, rb(), 1'b1, 1'b0));
    gen_idle(1'b0, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive(c);
      checks++;
      if (obs !== c.exp || obs_cnt !== c.cnt) begin
        failures++;
        $display("FAIL wait_addi outputs=%h count=%0d required %h/%0d", obs, obs_cnt, c.exp, c.cnt);
      end
    end
  endtask

  task automatic test_random();
    cyc_t c;
    bit   at_fetch = 1'b0;
    bit   run_mode = 1'b0;
    logic r, s;
    int   waits;
    for (int n = 0; n < 60; n++) begin
      if (!at_fetch) begin
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) gen_idle(1'b0, 1'b0);
        r = rb();
        s = r ? rb() : 1'b1;
        gen_idle(r, s);
        run_mode = r;
      end
      waits = ($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 3));
      at_fetch = gen_instr(4'($urandom_range(0, 14)), waits, rb(), run_mode,
                           1'($urandom_range(0, 3) != 0));
    end
    if (!at_fetch) gen_idle(1'b0, 1'b0);
    else void'(gen_instr(4'h3, 0, 1'b0, 1'b1, 1'b0));
    gen_idle(1'b0, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive(c);
      checks++;
      if (obs !== c.exp || obs_cnt !== c.cnt) begin
        failures++;
        $display("FAIL random outputs=%h count=%0d required %h/%0d", obs, obs_cnt, c.exp, c.cnt);
      end
    end
  endtask

  task automatic test_timeout();
    cyc_t c;
    gen_idle(1'b1, 1'b0);
    void'(gen_instr(4'h2, TMO - 1, 1'b0, 1'b1, 1'b1));  // one cycle short: no fault
    for (int i = 0; i < TMO; i++)
      push(1'b1, rb(), 1'b0, rop(), rb(), 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    gen_hold(3'd6, 1'b0, 1'b1, 6);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive(c);
      checks++;
      if (obs !== c.exp || obs_cnt !== c.cnt) begin
        failures++;
        $display("FAIL timeout outputs=%h count=%0d required %h/%0d", obs, obs_cnt, c.exp, c.cnt);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (snap() !== 13'd0 || instr_count !== '0) begin
      failures++;
      $display("FAIL fault_reset outputs=%h count=%0d required 0/0", snap(), instr_count);
    end
    @(posedge CLK);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_halt_and_abort();
    cyc_t c;
    gen_idle(1'b1, 1'b0);
    void'(gen_instr(4'h1, 0, 1'b0, 1'b1, 1'b1));
    void'(gen_instr(4'hF, 0, 1'b0, 1'b1, 1'b1));
    gen_hold(3'd5, 1'b1, 1'b0, 6);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive(c);
      checks++;
      if (obs !== c.exp || obs_cnt !== c.cnt) begin
        failures++;
        $display("FAIL halt outputs=%h count=%0d required %h/%0d", obs, obs_cnt, c.exp, c.cnt);
      end
    end
    reset = 1'b0;
    @(posedge CLK);
    #1;
    reset = 1'b1;
    model_reset();
    // SUBI retires, then the next instruction is aborted during DECODE.
    gen_idle(1'b1, 1'b0);
    void'(gen_instr(4'h5, 0, 1'b0, 1'b1, 1'b1));
    push(1'b1, 1'b0, 1'b1, rop(), rb(), 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive(c);
      checks++;
      if (obs !== c.exp || obs_cnt !== c.cnt) begin
        failures++;
        $display("FAIL pre_abort outputs=%h count=%0d required %h/%0d", obs, obs_cnt, c.exp, c.cnt);
      end
    end
    run = 1'b1; imem_ready = 1'b1; opcode = 4'h3; step = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (snap() !== 13'd0 || instr_count !== '0) begin
      failures++;
      $display("FAIL abort_async outputs=%h count=%0d required 0/0", snap(), instr_count);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (snap() !== 13'd0 || instr_count !== '0) begin
      failures++;
      $display("FAIL abort_edge outputs=%h count=%0d required 0/0", snap(), instr_count);
    end
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_alu();
    test_step_beq();
    test_wait_addi();
    test_random();
    test_timeout();
    test_halt_and_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
